mult_div_unit: RTL



---
 rtl/md_pkg.sv | 20 ++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared types for the iterative multiply/divide unit and the control decode.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Operands are reduced to magnitudes at Start; signs are reapplied in FIX.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MdOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t        state;
    md_op_t           op_q;
    logic             neg_p;
    logic             neg_r;
    logic [WIDTH-1:0] opnd;    // |A| for multiply, |B| for divide
    logic [WIDTH:0]   acc_hi;  // P_hi (top bit unused) or 33-bit remainder R
    logic [WIDTH-1:0] acc_lo;  // P_lo or quotient Q
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dz_q;

    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             is_div;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   mul_nh;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0] rem;

    always_comb begin
        in_signed = ~MdOp[0];
        in_div    = MdOp[1];
        abs_a     = (in_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        abs_b     = (in_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // One WIDTH+1-bit adder: add for multiply, subtract (x + ~y + 1) for divide.
    always_comb begin
        is_div  = op_q[1];
        r_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        add_x   = is_div ? r_shift : {1'b0, acc_hi[WIDTH-1:0]};
        add_y   = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
        sum     = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};

        mul_nh  = acc_lo[0] ? sum[WIDTH:0] : {1'b0, acc_hi[WIDTH-1:0]};
        if (is_div) begin
            // sum[WIDTH+1] is the no-borrow flag, i.e. R >= |B|
            step_hi = sum[WIDTH+1] ? sum[WIDTH:0] : r_shift;
            step_lo = {acc_lo[WIDTH-2:0], sum[WIDTH+1]};
        end else begin
            step_hi = {1'b0, mul_nh[WIDTH:1]};
            step_lo = {mul_nh[0], acc_lo[WIDTH-1:1]};
        end

        prod     = {acc_hi[WIDTH-1:0], acc_lo};
        prod_neg = ~prod + 1'b1;
        rem      = acc_hi[WIDTH-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            op_q   <= MD_MULT;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    if (Start) begin
                        op_q  <= md_op_t'(MdOp);
                        neg_p <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r <= in_signed & A[WIDTH-1];
                        cnt   <= '0;
                        if (in_div && (B == '0)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                        end else if (in_div) begin
                            state  <= CALC;
                            opnd   <= abs_b;
                            acc_hi <= '0;
                            acc_lo <= abs_a;
                        end else begin
                            state  <= CALC;
                            opnd   <= abs_a;
                            acc_hi <= '0;
                            acc_lo <= abs_b;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo_q <= neg_p ? (~acc_lo + 1'b1) : acc_lo;
                        hi_q <= neg_r ? (~rem + 1'b1) : rem;
                    end else begin
                        {hi_q, lo_q} <= neg_p ? prod_neg : prod;
                    end
                    state  <= DONE;
                    done_q <= 1'b1;
                    dz_q   <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy    = (state != IDLE);
    assign Done    = done_q;
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
